// File: rtl/piso_shift_transmitter.sv
// Parallel-in / serial-out transmitter with valid/ready word intake and
// frame start/done strobes; back-to-back words stream with no idle gap.
module piso_shift_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  input  logic                  Data_Valid_In,
  output logic                  Ready_Out,
  output logic                  Serial_Data_Out,
  output logic                  Serial_Valid_Out,
  output logic                  Frame_Start_Out,
  output logic                  Frame_Done_Out,
  output logic [DATA_WIDTH-1:0] PISO_Shift_Register
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  last_bit, accept;

  // The last-bit cycle is also a ready cycle so the next word loads gap-free.
  assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST);
  assign Ready_Out = ~Reset_In & ((state_q == IDLE) | last_bit);
  assign accept    = Data_Valid_In & Ready_Out;

  assign PISO_Shift_Register = sr_q;

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    sr_d             = sr_q;
    Serial_Data_Out  = 1'b0;
    Serial_Valid_Out = 1'b0;
    Frame_Start_Out  = 1'b0;
    Frame_Done_Out   = 1'b0;

    if (accept) begin
      sr_d    = Parallel_Data_In;
      state_d = SHIFT;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d = IDLE;
        sr_d    = '0;
        cnt_d   = '0;
      end else begin
        // Zero-filled shift toward whichever end drives the serial line.
        sr_d  = (MSB_FIRST != 0) ? {sr_q[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, sr_q[DATA_WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (state_q == SHIFT) begin
      Serial_Data_Out  = (MSB_FIRST != 0) ? sr_q[DATA_WIDTH-1] : sr_q[0];
      Serial_Valid_Out = 1'b1;
      Frame_Start_Out  = (cnt_q == '0);
      Frame_Done_Out   = last_bit;
    end
  end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
// Directed bench: MSB-first and LSB-first instances plus an 8-bit SISO
// receiver model on the MSB-first serial line.
module tb_piso_shift_transmitter;

  logic clk;
  int   errors = 0;
  int   checks = 0;

  logic       m_rst, m_vld, m_rdy, m_ser, m_sv, m_fs, m_fd;
  logic [7:0] m_data, m_sr;
  logic       l_rst, l_vld, l_rdy, l_ser, l_sv, l_fs, l_fd;
  logic [7:0] l_data, l_sr;
  logic       siso_clr;
  logic [7:0] siso;

  piso_shift_transmitter #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
    .Clk_In(clk), .Reset_In(m_rst), .Parallel_Data_In(m_data),
    .Data_Valid_In(m_vld), .Ready_Out(m_rdy), .Serial_Data_Out(m_ser),
    .Serial_Valid_Out(m_sv), .Frame_Start_Out(m_fs), .Frame_Done_Out(m_fd),
    .PISO_Shift_Register(m_sr)
  );

  piso_shift_transmitter #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .Clk_In(clk), .Reset_In(l_rst), .Parallel_Data_In(l_data),
    .Data_Valid_In(l_vld), .Ready_Out(l_rdy), .Serial_Data_Out(l_ser),
    .Serial_Valid_Out(l_sv), .Frame_Start_Out(l_fs), .Frame_Done_Out(l_fd),
    .PISO_Shift_Register(l_sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving SISO register, MSB-first: each valid bit enters at bit 0.
  always @(posedge clk) begin
    if (siso_clr)  siso <= 8'h00;
    else if (m_sv) siso <= {siso[6:0], m_ser};
  end

  task automatic test_reset();
    m_rst = 1; l_rst = 1; m_vld = 0; l_vld = 0; m_data = 0; l_data = 0;
    siso_clr = 1;
    @(negedge clk);
    checks++;
    if ({m_ser, m_sv, m_fs, m_fd, m_rdy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_msb_outs: got %b expected 00000", {m_ser, m_sv, m_fs, m_fd, m_rdy});
    end
    checks++;
    if (m_sr !== 8'h00) begin
      errors++;
      $display("FAIL reset_msb_sr: got %h expected 00", m_sr);
    end
    checks++;
    if ({l_ser, l_sv, l_fs, l_fd, l_rdy, l_sr} !== 13'b0) begin
      errors++;
      $display("FAIL reset_lsb: got %b expected all zero", {l_ser, l_sv, l_fs, l_fd, l_rdy, l_sr});
    end
    m_rst = 0; l_rst = 0; siso_clr = 0;
    #1;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", m_rdy);
    end
    checks++;
    if (l_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready_lsb: got %b expected 1", l_rdy);
    end
  endtask

  task automatic idle_check_msb(input string tag);
    checks++;
    if ({m_ser, m_sv, m_fs, m_fd, m_rdy} !== 5'b00001) begin
      errors++;
      $display("FAIL %s_idle: got ser/sv/fs/fd/rdy=%b expected 00001", tag, {m_ser, m_sv, m_fs, m_fd, m_rdy});
    end
    checks++;
    if (m_sr !== 8'h00) begin
      errors++;
      $display("FAIL %s_idle_sr: got %h expected 00", tag, m_sr);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_bits = 8'b10111001;
    logic [3:0] e;
    m_data = 8'hB9; m_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_vld = 0;
      if (i == 0) begin
        checks++;
        if (m_sr !== 8'hB9) begin
          errors++;
          $display("FAIL single_load_sr: got %h expected b9", m_sr);
        end
      end
      e = {exp_bits[7-i], 1'b1, (i == 0), (i == 7)};
      checks++;
      if ({m_ser, m_sv, m_fs, m_fd} !== e) begin
        errors++;
        $display("FAIL single_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {m_ser, m_sv, m_fs, m_fd}, e);
      end
    end
    @(negedge clk);
    idle_check_msb("single");
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_bits = 16'b1011100101001100;
    logic [3:0]  e;
    m_data = 8'hB9; m_vld = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 7) m_data = 8'h4C;
      if (i == 8) m_vld = 0;
      #1;
      if (i == 3 || i == 7) begin
        checks++;
        if (m_rdy !== (i == 7)) begin
          errors++;
          $display("FAIL b2b_ready_bit%0d: got %b expected %b", i + 1, m_rdy, (i == 7));
        end
      end
      e = {exp_bits[15-i], 1'b1, (i == 0 || i == 8), (i == 7 || i == 15)};
      checks++;
      if ({m_ser, m_sv, m_fs, m_fd} !== e) begin
        errors++;
        $display("FAIL b2b_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {m_ser, m_sv, m_fs, m_fd}, e);
      end
    end
    @(negedge clk);
    idle_check_msb("b2b");
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp_bits = 8'b10111001;
    logic [3:0] e;
    m_data = 8'hB9; m_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_vld = 0;
      if (i == 2) begin
        m_vld = 1; m_data = 8'hFF;
        #1;
        checks++;
        if (m_rdy !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: got %b expected 0", m_rdy);
        end
      end
      e = {exp_bits[7-i], 1'b1, (i == 0), (i == 7)};
      checks++;
      if ({m_ser, m_sv, m_fs, m_fd} !== e) begin
        errors++;
        $display("FAIL busy_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {m_ser, m_sv, m_fs, m_fd}, e);
      end
    end
    @(negedge clk);
    idle_check_msb("busy");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_a = 8'b10111001;
    logic [7:0] exp_b = 8'b00001111;
    logic [3:0] e;
    m_data = 8'hB9; m_vld = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_vld = 0;
      e = {exp_a[7-i], 1'b1, (i == 0), 1'b0};
      checks++;
      if ({m_ser, m_sv, m_fs, m_fd} !== e) begin
        errors++;
        $display("FAIL midrst_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {m_ser, m_sv, m_fs, m_fd}, e);
      end
      if (i == 4) m_rst = 1;
    end
    @(negedge clk);
    checks++;
    if ({m_ser, m_sv, m_fs, m_fd, m_rdy, m_sr} !== 13'b0) begin
      errors++;
      $display("FAIL midrst_abort: got ser/sv/fs/fd/rdy/sr=%b expected all zero", {m_ser, m_sv, m_fs, m_fd, m_rdy, m_sr});
    end
    m_rst = 0;
    #1;
    checks++;
    if (m_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected 1", m_rdy);
    end
    m_data = 8'h0F; m_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_vld = 0;
      e = {exp_b[7-i], 1'b1, (i == 0), (i == 7)};
      checks++;
      if ({m_ser, m_sv, m_fs, m_fd} !== e) begin
        errors++;
        $display("FAIL midrst_new_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {m_ser, m_sv, m_fs, m_fd}, e);
      end
    end
    @(negedge clk);
    idle_check_msb("midrst");
  endtask

  task automatic test_lsb_first();
    logic [15:0] exp_bits = 16'b1000000000000001;
    logic [3:0]  e;
    l_data = 8'h01; l_vld = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 7) l_data = 8'h80;
      if (i == 8) l_vld = 0;
      e = {exp_bits[15-i], 1'b1, (i == 0 || i == 8), (i == 7 || i == 15)};
      checks++;
      if ({l_ser, l_sv, l_fs, l_fd} !== e) begin
        errors++;
        $display("FAIL lsb_bit%0d: got ser/sv/fs/fd=%b expected %b", i + 1, {l_ser, l_sv, l_fs, l_fd}, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({l_ser, l_sv, l_fs, l_fd, l_rdy, l_sr} !== 13'b0_0_0_0_1_00000000) begin
      errors++;
      $display("FAIL lsb_idle: got %b expected 0000100000000", {l_ser, l_sv, l_fs, l_fd, l_rdy, l_sr});
    end
  endtask

  task automatic test_loopback();
    int nvalid = 0;
    siso_clr = 1;
    @(negedge clk);
    siso_clr = 0;
    m_data = 8'hB9; m_vld = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_vld = 0;
      if (m_sv === 1'b1) nvalid++;
    end
    @(negedge clk);
    checks++;
    if (nvalid != 8) begin
      errors++;
      $display("FAIL loopback_valid_count: got %0d expected 8", nvalid);
    end
    checks++;
    if (siso !== 8'hB9) begin
      errors++;
      $display("FAIL loopback_siso: got %h expected b9", siso);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
    test_lsb_first();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_shift_transmitter.md
Name: piso_shift_transmitter

Overview:
- Parallel-In-Serial-Out transmitter. It is the sending end of the serial shift-register chain: it accepts a parallel word through a valid/ready handshake and drives it out one bit per clock.
- Its serial output feeds the existing Serial-In-Serial-Out / Serial-In-Parallel-Out shift registers directly.
- It adds frame-start and frame-done strobes so the receiving side can align words.
- Back-to-back words stream with no idle gap.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be 2 or more.
- MSB_FIRST, 1: 1 = transmit bit DATA_WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- Clk_In  input  1  clock; all state changes on the rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Parallel_Data_In  input  DATA_WIDTH  word to transmit; sampled only on accept.
- Data_Valid_In  input  1  Parallel_Data_In is valid.
- Ready_Out  output  1  block can accept a word this cycle.
- Serial_Data_Out  output  1  current serial bit; 0 when not transmitting.
- Serial_Valid_Out  output  1  high on every cycle a frame bit is driven.
- Frame_Start_Out  output  1  one-cycle pulse coincident with the first bit of a frame.
- Frame_Done_Out  output  1  one-cycle pulse coincident with the last bit of a frame.
- PISO_Shift_Register  output  DATA_WIDTH  internal shift register contents, for debug and bench.

Behaviour:
- Interface: one clock, Clk_In. Reset_In is synchronous and active-high.
- Reset: on any edge with Reset_In=1:
  - state becomes IDLE, bit counter 0, PISO_Shift_Register 0;
  - Serial_Data_Out, Serial_Valid_Out, Frame_Start_Out and Frame_Done_Out are 0;
  - Ready_Out is held 0 while Reset_In=1.
- Reset mid-frame aborts immediately. The partial frame is discarded and no Frame_Done_Out pulse is issued.
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is in progress; bit counter cnt runs 0..DATA_WIDTH-1.
- Ready_Out is combinational: ~Reset_In & (state==IDLE | (state==SHIFT & cnt==DATA_WIDTH-1)).
- Accept occurs at an edge where Data_Valid_In=1 and Ready_Out=1. On accept:
  - PISO_Shift_Register <= Parallel_Data_In;
  - state <= SHIFT, cnt <= 0.
- Data_Valid_In while Ready_Out=0 is ignored; the word is not captured, and the source must hold it.
- Latency: the first bit appears in the cycle immediately after the accept edge.
- In SHIFT:
  - Serial_Data_Out = PISO_Shift_Register[DATA_WIDTH-1] if MSB_FIRST=1, else PISO_Shift_Register[0].
  - Serial_Valid_Out = 1.
  - Frame_Start_Out = (cnt==0).
  - Frame_Done_Out = (cnt==DATA_WIDTH-1).
- In IDLE: Serial_Data_Out, Serial_Valid_Out and both strobes are 0.
- Each SHIFT edge without a new accept:
  - register shifts one place toward the output end, zero filling (left if MSB_FIRST=1, right otherwise);
  - cnt increments.
- Frame length: exactly DATA_WIDTH consecutive Serial_Valid_Out cycles per accepted word.
- End of frame, last-bit edge (cnt==DATA_WIDTH-1):
  - with accept: load the new word, cnt <= 0, stay in SHIFT. The next frame follows with zero gap, and Frame_Start_Out follows Frame_Done_Out in the very next cycle.
  - without accept: state <= IDLE and the register clears to 0.
- Reset has priority over accept on the same edge.
- cnt width is clog2(DATA_WIDTH). It never wraps past DATA_WIDTH-1.

Test Plan:
- Reset, then single word, MSB_FIRST=1, DATA_WIDTH=8:
  - stimulus: Reset_In=1 for 1 edge, then present 0xB9 with Data_Valid_In=1 for one accepted edge;
  - response: the next 8 cycles show Serial_Data_Out = 1,0,1,1,1,0,0,1, with Serial_Valid_Out=1 throughout;
  - Frame_Start_Out high on cycle 1 only, Frame_Done_Out high on cycle 8 only;
  - then IDLE, outputs 0, Ready_Out=1.
- Back-to-back:
  - stimulus: accept 0xB9, hold Data_Valid_In=1 with 0x4C presented at the last-bit cycle;
  - response: 16 consecutive valid bits: 10111001 then 01001100;
  - Frame_Done_Out at bit 8 and Frame_Start_Out at bit 9 in adjacent cycles, with no gap.
- Busy ignore:
  - stimulus: during bit 3 of 0xB9, drive Data_Valid_In=1 with 0xFF for one cycle;
  - response: Ready_Out=0 then, the word is not captured, the 0xB9 bit stream is unchanged, and the block returns to IDLE after bit 8.
- Reset mid-frame:
  - stimulus: assert Reset_In during bit 5 of 0xB9;
  - response: the next cycle shows all outputs 0 and PISO_Shift_Register=0, with no Frame_Done_Out pulse;
  - after release, Ready_Out=1 and a new 0x0F transmits as 0,0,0,0,1,1,1,1.
- LSB first:
  - stimulus: MSB_FIRST=0, send 0x01 then 0x80 back-to-back;
  - response: 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Loopback:
  - stimulus: connect Serial_Data_Out to the existing 8-bit SISO register input and send 0xB9;
  - response: after 8 valid cycles the SISO register holds the transmitted word.
